// File: rtl/alu_opnd_sel_pipe.sv
// rtl/alu_opnd_sel_pipe.sv - double-buffered operand selector feeding one valid/ready register stage
// Optional build macro OPND_SEL_OOR_ERR_EN adds the sticky out-of-range select flag (err_oor/err_clr).
module alu_opnd_sel_pipe #(
  parameter int DATA_W  = 16,
  parameter int NUM_IN  = 8,
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 3,
  parameter int IDX_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      conf_we,
  input  logic [IDX_W-1:0]          conf_idx,
  input  logic [SEL_W-1:0]          conf_sel,
  input  logic                      conf_swap,
  output logic [NUM_OUT*SEL_W-1:0]  act_sel
`ifdef OPND_SEL_OOR_ERR_EN
  ,
  output logic                      err_oor,
  input  logic                      err_clr
`endif
);

  logic [NUM_OUT-1:0][SEL_W-1:0]  shd, shd_nxt, act;
  logic [NUM_OUT-1:0][DATA_W-1:0] sel_data;
  logic                           xfer;

  // Out-of-range operand indices never match any k, so such writes drop out here.
  always_comb begin
    shd_nxt = shd;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (conf_we && (32'(conf_idx) == k)) shd_nxt[k] = conf_sel;
    end
  end

  // Swapping from shd_nxt forwards a same-cycle shadow write into the active bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd <= '0;
      act <= '0;
    end else begin
      shd <= shd_nxt;
      if (conf_swap) act <= shd_nxt;
    end
  end

  assign act_sel = act;

  // Codes with no matching lane leave the operand at its zero default.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (32'(act[k]) == i) sel_data[k] = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OPND_SEL_OOR_ERR_EN
  logic oor_hit;

  always_comb begin
    oor_hit = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (32'(act[k]) >= NUM_IN) oor_hit = 1'b1;
    end
  end

  // A bad transfer in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_oor <= 1'b0;
    else if (xfer && oor_hit)  err_oor <= 1'b1;
    else if (err_clr)          err_oor <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_opnd_sel_pipe.sv
// tb/tb_alu_opnd_sel_pipe.sv - randomized and directed bench for alu_opnd_sel_pipe against a lane-level model
module tb_alu_opnd_sel_pipe;
  localparam int DW = 16, NI = 6, NO = 2, SW = 3, IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI*DW-1:0]  in_data;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [NO*DW-1:0]  out_data;
  logic              conf_we, conf_swap;
  logic [IW-1:0]     conf_idx;
  logic [SW-1:0]     conf_sel;
  logic [NO*SW-1:0]  act_sel;
`ifdef OPND_SEL_OOR_ERR_EN
  logic err_oor, err_clr;
  bit   m_err;
`endif

  alu_opnd_sel_pipe #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO), .SEL_W(SW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .conf_we(conf_we), .conf_idx(conf_idx), .conf_sel(conf_sel), .conf_swap(conf_swap),
    .act_sel(act_sel)
`ifdef OPND_SEL_OOR_ERR_EN
    , .err_oor(err_oor), .err_clr(err_clr)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, seq = 0;
  int lane[NI];
  int m_shd[NO], m_act[NO];
  bit m_valid;
  logic [NO*DW-1:0] m_data, hold;
  logic [NO*DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NO*DW-1:0] pick();
    logic [NO*DW-1:0] r = '0;
    for (int k = 0; k < NO; k++)
      if (m_act[k] < NI) r[k*DW +: DW] = lane[m_act[k]][DW-1:0];
    return r;
  endfunction

  function automatic logic [NO*SW-1:0] pack_act();
    logic [NO*SW-1:0] r = '0;
    for (int k = 0; k < NO; k++) r[k*SW +: SW] = m_act[k][SW-1:0];
    return r;
  endfunction

  task automatic set_lanes(input int base);
    for (int i = 0; i < NI; i++) lane[i] = base + i;
  endtask

  task automatic cfg(input bit we, input int idx, input int sel, input bit swap);
    conf_we = we; conf_idx = idx[IW-1:0]; conf_sel = sel[SW-1:0]; conf_swap = swap;
  endtask

  task automatic model_reset();
    m_valid = 0;
    for (int k = 0; k < NO; k++) begin m_shd[k] = 0; m_act[k] = 0; end
    exp_q.delete();
`ifdef OPND_SEL_OOR_ERR_EN
    m_err = 0;
`endif
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_act"}, act_sel, 0);
`ifdef OPND_SEL_OOR_ERR_EN
    check({tag, "_err"}, err_oor, 0);
`endif
  endtask

  // One clock: check handshake before the edge, advance the model at the edge, check state after it.
  task automatic cyc();
    bit xf, oor;
    for (int i = 0; i < NI; i++) in_data[i*DW +: DW] = lane[i][DW-1:0];
    #2;
    check("in_ready", in_ready, !m_valid || out_ready);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_extra_beat", out_valid, 0);
      else check("sb_beat", out_data, exp_q.pop_front());
    end
    xf  = in_valid && (!m_valid || out_ready);
    oor = 0;
    for (int k = 0; k < NO; k++) if (m_act[k] >= NI) oor = 1;
    @(posedge clk);
    if (xf) begin
      m_data = pick(); m_valid = 1; exp_q.push_back(m_data);
    end else if (out_ready) m_valid = 0;
`ifdef OPND_SEL_OOR_ERR_EN
    if (xf && oor) m_err = 1;
    else if (err_clr) m_err = 0;
`endif
    for (int k = 0; k < NO; k++) if (conf_we && int'(conf_idx) == k) m_shd[k] = int'(conf_sel);
    if (conf_swap) for (int k = 0; k < NO; k++) m_act[k] = m_shd[k];
    #1;
    check("out_valid", out_valid, m_valid);
    if (m_valid) check("out_data", out_data, m_data);
    check("act_sel", act_sel, pack_act());
`ifdef OPND_SEL_OOR_ERR_EN
    check("err_oor", err_oor, m_err);
`endif
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; in_data = '0;
    cfg(0, 0, 0, 0);
`ifdef OPND_SEL_OOR_ERR_EN
    err_clr = 0;
`endif
    set_lanes(0);
    model_reset();
    #1 reset_checks("rst");
    @(negedge clk) rst_n = 1;

    // first beat after reset selects lane 0 for both operands
    set_lanes(16'h1000); in_valid = 1; out_ready = 1;
    cyc();
    check("t1_opnd", out_data, 32'h1000_1000);

    // shadow writes are invisible until the swap; the swap beat still uses the old bank
    cfg(1, 0, 3, 0); cyc();
    cfg(1, 1, 5, 0); cyc();
    check("t2_noswap", out_data, 32'h1000_1000);
    cfg(0, 0, 0, 1); cyc();
    check("t2_swap_beat", out_data, 32'h1000_1000);
    cfg(0, 0, 0, 0); cyc();
    check("t2_new_bank", out_data, 32'h1005_1003);
    check("t2_act", act_sel, 6'b101_011);

    // stall with changing lanes and a swap: output holds, then stream resumes
    set_lanes(16'h2000); cyc();
    hold = out_data;
    check("t3_cap", hold, 32'h2005_2003);
    out_ready = 0;
    for (int j = 0; j < 4; j++) begin
      set_lanes(16'h3000 + 16 * j);
      if (j == 1) cfg(1, 0, 1, 0); else if (j == 2) cfg(0, 0, 0, 1); else cfg(0, 0, 0, 0);
      cyc();
      check("t3_hold", out_data, hold);
      check("t3_stall", in_ready, 0);
    end
    cfg(0, 0, 0, 0); out_ready = 1;
    for (int j = 0; j < 6; j++) begin seq++; set_lanes(seq * 8); cyc(); end

    // forwarded write+swap, and an ignored write to a nonexistent operand
    cfg(1, 1, 7, 1); cyc();
    check("t4_fwd", act_sel[5:3], 7);
    cfg(1, 2, 4, 1); cyc();
    check("t4_idx_oor", act_sel, 6'b111_001);
    cfg(0, 0, 0, 0);

    // out-of-range selects yield 0
    set_lanes(16'h4000); cyc();
    check("t5_b7", out_data[31:16], 0);
    cfg(1, 1, 6, 1); cyc();
    cfg(0, 0, 0, 0); cyc();
    check("t5_b6", out_data[31:16], 0);
    check("t5_a", out_data[15:0], 16'h4001);
`ifdef OPND_SEL_OOR_ERR_EN
    check("t5_err_set", err_oor, 1);
    err_clr = 1; cyc();
    check("t5_set_wins", err_oor, 1);
    in_valid = 0; cyc();
    check("t5_cleared", err_oor, 0);
    err_clr = 0; in_valid = 1;
`endif

    // async reset in the middle of a stall
    cfg(1, 0, 2, 1); cyc();
    cfg(0, 0, 0, 0); out_ready = 0; cyc(); cyc();
    check("t6_stalled", out_valid, 1);
    #2 rst_n = 0;
    model_reset();
    #1 reset_checks("t6_rst");
    @(negedge clk) rst_n = 1;
    set_lanes(16'h5000); out_ready = 1; in_valid = 1;
    cyc();
    check("t6_lane0", out_data, 32'h5000_5000);

    // randomized traffic and reconfiguration
    for (int n = 0; n < 400; n++) begin
      seq++;
      for (int i = 0; i < NI; i++) lane[i] = (seq * 8 + i) & 16'hffff;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg($urandom_range(0, 4) == 0, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7) == 0);
`ifdef OPND_SEL_OOR_ERR_EN
      err_clr = ($urandom_range(0, 5) == 0);
`endif
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_opnd_sel_pipe.md
Name: alu_opnd_sel_pipe

Overview:
Parametrised successor of the PE operand selector. Picks NUM_OUT operands from NUM_IN packed source lanes (neighbours, delay lines, constants) using per-operand select codes. Select codes are double-buffered: a shadow bank is written by the config loader and swapped atomically into the active bank, so a PE context can change without a glitch. Selected operands pass through one valid/ready pipeline register and are presented to the ALU as OUT_DATA.

Parameters:
DATA_W, 16, width of each data lane
NUM_IN, 8, number of source lanes; lane 0 is IN_DATA[DATA_W-1:0]
NUM_OUT, 2, number of operands (A, B, ...); operand 0 is OUT_DATA[DATA_W-1:0]
SEL_W, 3, select code width; must satisfy 2**SEL_W >= NUM_IN
IDX_W, 1, operand index width; must satisfy 2**IDX_W >= NUM_OUT

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
IN_DATA  in  NUM_IN*DATA_W  packed source lanes
IN_VALID  in  1  source lanes valid this cycle
IN_READY  out  1  stage can accept
OUT_DATA  out  NUM_OUT*DATA_W  registered packed operands
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  ALU consumes OUT_DATA
CONF_WE  in  1  write shadow select
CONF_IDX  in  IDX_W  operand index of shadow write
CONF_SEL  in  SEL_W  select code written
CONF_SWAP  in  1  copy shadow bank to active bank
ACT_SEL  out  NUM_OUT*SEL_W  active select bank, for debug and readback

Behaviour:
- Reset (RST_N low, asynchronous): the shadow bank and the active bank go to all 0, so every operand selects lane 0. OUT_DATA=0, OUT_VALID=0. IN_READY=1 while in reset.
- Select is combinational from the active bank. For each operand k, sel_k = IN_DATA lane ACT_SEL[k]. If ACT_SEL[k] >= NUM_IN, sel_k = 0.
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY.
  - A transfer occurs when IN_VALID && IN_READY. On a transfer, OUT_DATA <= {sel_k} and OUT_VALID <= 1.
  - When OUT_READY is high and there is no transfer, OUT_VALID <= 0.
  - While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_VALID hold.
  - Latency is 1 cycle. Full throughput is 1 transfer per cycle when OUT_READY stays high.
  - IN_VALID may drop at any time; nothing is captured while it is low.
- Shadow write: on CONF_WE, SHD[CONF_IDX] <= CONF_SEL. A write with CONF_IDX >= NUM_OUT is ignored.
- Swap: on CONF_SWAP, ACT <= SHD at the clock edge.
  - A transfer in the same cycle as the swap uses the old active bank. The first transfer after the edge uses the new bank.
  - If CONF_WE and CONF_SWAP are asserted together, the written value is forwarded, so ACT[CONF_IDX] gets the new CONF_SEL. The shadow bank is updated as well.
- The config path is independent of the handshake. A swap during a stall does not alter the held OUT_DATA.
- ACT_SEL reflects the active bank directly (registered value).

Optional Feature:
Macro OPND_SEL_OOR_ERR_EN.
- Defined:
  - Extra ports ERR_OOR (out, 1) and ERR_CLR (in, 1).
  - ERR_OOR is sticky. It sets on any transfer where some ACT_SEL[k] >= NUM_IN.
  - ERR_CLR clears ERR_OOR. If set and clear happen in the same cycle, set wins.
  - ERR_OOR resets to 0.
- Not defined: no extra ports, no error logic. An out-of-range select silently yields 0.
- Operand data behaviour is identical in both builds.

Test Plan:
1. Reset, then IN_VALID=1 with lanes L_i=0x1000+i, OUT_READY=1 -> next cycle OUT_VALID=1 and both operands equal 0x1000.
2. Write shadow A=3, B=5, no swap, send a transfer -> operands are 0x1000/0x1000. Pulse CONF_SWAP together with a transfer -> that beat is still 0x1000/0x1000, the next beat is 0x1003/0x1005, and ACT_SEL = {5,3}.
3. Accept a beat, then hold OUT_READY=0 for 4 cycles while lanes change and a swap occurs -> OUT_DATA is stable and IN_READY=0. Raise OUT_READY -> one handoff, then streaming resumes with no lost or duplicated beat (sequence numbers checked).
4. CONF_WE(idx=1, sel=7) together with CONF_SWAP -> ACT_SEL[1]=7 on the next cycle. CONF_WE with idx=2 (NUM_OUT=2) -> no state change.
5. With NUM_IN=6, swap B to 6, then a transfer -> operand B = 0. With OPND_SEL_OOR_ERR_EN: ERR_OOR=1 and stays 1. ERR_CLR with no bad transfer -> 0. ERR_CLR during a bad transfer -> stays 1.
6. Drop RST_N mid-stall with OUT_VALID=1 -> OUT_VALID and OUT_DATA go to 0 immediately and both banks go to 0. After release, the first beat selects lane 0.
